// File: rtl/boot_loader.sv
// Byte-stream boot loader: frames of header/data/checksum bytes are packed into
// 32-bit words and written to the icache boot port; the core is released on a good checksum.
module boot_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        host_valid,
    input  logic [7:0]  host_data,
    output logic        host_ready,
    output logic        boot_up,
    output logic [7:0]  boot_addr,
    output logic [31:0] boot_datai,
    output logic        boot_web,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, WRITE, CHK, DONE, ERR
    } state_t;

    state_t      state_reg;
    logic [7:0]  n_last_reg;     // index of the final word (header minus one, so 0 means 256 words)
    logic [7:0]  idx_reg;
    logic [7:0]  csum_reg;
    logic [1:0]  byte_cnt_reg;
    logic [31:0] word_reg;

    logic        host_ready_reg;
    logic        boot_up_reg;
    logic [7:0]  boot_addr_reg;
    logic [31:0] boot_datai_reg;
    logic        boot_web_reg;
    logic        done_reg;
    logic        err_reg;

    logic accept;
    assign accept = host_valid & host_ready_reg;

    assign host_ready = host_ready_reg;
    assign boot_up    = boot_up_reg;
    assign boot_addr  = boot_addr_reg;
    assign boot_datai = boot_datai_reg;
    assign boot_web   = boot_web_reg;
    assign done       = done_reg;
    assign err        = err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            n_last_reg     <= 8'd0;
            idx_reg        <= 8'd0;
            csum_reg       <= 8'd0;
            byte_cnt_reg   <= 2'd0;
            word_reg       <= 32'd0;
            host_ready_reg <= 1'b0;
            boot_up_reg    <= 1'b1;
            boot_addr_reg  <= 8'd0;
            boot_datai_reg <= 32'd0;
            boot_web_reg   <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= HDR;
                        host_ready_reg <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        n_last_reg   <= host_data - 8'd1;
                        idx_reg      <= 8'd0;
                        byte_cnt_reg <= 2'd0;
                        csum_reg     <= 8'd0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum_reg <= csum_reg + host_data;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        word_reg[{byte_cnt_reg, 3'b000} +: 8] <= host_data;
                        // Fourth byte goes straight to the port register, bypassing word_reg.
                        if (byte_cnt_reg == 2'd3) begin
                            boot_datai_reg <= {host_data, word_reg[23:0]};
                            boot_addr_reg  <= BASE_ADDR + idx_reg;
                            boot_web_reg   <= 1'b0;
                            host_ready_reg <= 1'b0;
                            state_reg      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    boot_web_reg   <= 1'b1;
                    host_ready_reg <= 1'b1;
                    if (idx_reg == n_last_reg) begin
                        state_reg <= CHK;
                    end else begin
                        idx_reg   <= idx_reg + 8'd1;
                        state_reg <= DATA;
                    end
                end
                CHK: begin
                    if (accept) begin
                        host_ready_reg <= 1'b0;
                        if (host_data == csum_reg) begin
                            state_reg   <= DONE;
                            boot_up_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_reg      <= HDR;
                        boot_up_reg    <= 1'b1;
                        done_reg       <= 1'b0;
                        host_ready_reg <= 1'b1;
                    end
                end
                ERR: begin
                    if (start) begin
                        state_reg      <= HDR;
                        err_reg        <= 1'b0;
                        host_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
